// File: rtl/adder_pipe_pkg.sv
// Shared types, slice index helpers and configuration checks for the segmented pipelined adder.
package adder_pipe_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_NSEG  = 4;

    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
    } stage_ctl_t;

    function automatic int unsigned seg_lo(input int unsigned k, input int unsigned segw);
        return k * segw;
    endfunction

    function automatic int unsigned seg_hi(input int unsigned k, input int unsigned segw);
        return (k * segw) + segw - 1;
    endfunction

    // Legal geometry: at least one segment and an integral slice width.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned nseg);
        return (nseg >= 1) && (width >= nseg) && ((width % nseg) == 0);
    endfunction

endpackage

// File: rtl/adder_pipe_seg_if.sv
// Operand/result valid-ready bus of the segmented adder.
// ADDER_PIPE_SUB_EN adds the in_sub select that travels with each operand pair.
interface adder_pipe_seg_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_op0;
    logic [WIDTH-1:0] in_op1;
`ifdef ADDER_PIPE_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_valid, in_op0, in_op1, out_ready,
`ifdef ADDER_PIPE_SUB_EN
        output in_sub,
`endif
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_op0, in_op1, out_ready,
`ifdef ADDER_PIPE_SUB_EN
        input  in_sub,
`endif
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/adder_seg_stage.sv
// One carry segment: adds a SEGW-bit slice plus carry-in and registers sum and carry-out.
module adder_seg_stage #(
    parameter int unsigned SEGW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [SEGW-1:0] a,
    input  logic [SEGW-1:0] b,
    input  logic            cin,
    output logic [SEGW-1:0] sum,
    output logic            cout
);
    logic [SEGW:0] total_c;

    assign total_c = {1'b0, a} + {1'b0, b} + (SEGW+1)'(cin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            {cout, sum} <= total_c;
        end
    end
endmodule

// File: rtl/adder_pipe_seg.sv
// Carry-segmented pipelined adder: NSEG slices, one carry hop per stage, valid/ready with global stall.
// ADDER_PIPE_SUB_EN enables per-transfer subtraction (op0 - op1) via the in_sub bus signal.
module adder_pipe_seg
    import adder_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NSEG  = DEF_NSEG
) (
    input logic             clk,
    input logic             rst_n,
    adder_pipe_seg_if.slave bus
);
    localparam int unsigned SEGW = (NSEG == 0) ? WIDTH : WIDTH / NSEG;

    if (!cfg_ok(WIDTH, NSEG)) begin : gen_cfg_err
        $error("adder_pipe_seg: WIDTH=%0d must be a nonzero multiple of NSEG=%0d", WIDTH, NSEG);
    end

    logic                       adv;
    logic [NSEG:0]              valid_q;
    logic                       cin_q;
    logic [NSEG-1:0][WIDTH-1:0] a_q;
    logic [NSEG-1:0][WIDTH-1:0] b_q;
    logic [NSEG:1][WIDTH-1:0]   s_q;
    logic [NSEG:0][WIDTH-1:0]   done;
    logic [NSEG:1][SEGW-1:0]    seg_sum;
    logic [NSEG:1]              seg_cout;
    logic [NSEG:1]              seg_cin;

    // Whole pipe moves together; it only stalls when a finished result is refused.
    assign adv           = !valid_q[NSEG] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_q[NSEG];
    assign bus.out_sum   = done[NSEG];
    assign bus.out_cout  = seg_cout[NSEG];

    // Operand capture, operand skew buffers, completed-slice buffers and valid chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            cin_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
        end else if (adv) begin
            valid_q <= {valid_q[NSEG-1:0], bus.in_valid};
            a_q[0]  <= bus.in_op0;
`ifdef ADDER_PIPE_SUB_EN
            b_q[0]  <= bus.in_sub ? ~bus.in_op1 : bus.in_op1;
            cin_q   <= bus.in_sub;
`else
            b_q[0]  <= bus.in_op1;
            cin_q   <= 1'b0;
`endif
            for (int k = 1; k < int'(NSEG); k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int k = 1; k <= int'(NSEG); k++) begin
                s_q[k] <= done[k-1];
            end
        end
    end

    assign done[0] = '0;

    for (genvar k = 1; k <= NSEG; k++) begin : gen_stage
        localparam int unsigned LO = seg_lo(k - 1, SEGW);

        if (k == 1) begin : gen_cin_first
            assign seg_cin[k] = cin_q;
        end else begin : gen_cin_chain
            assign seg_cin[k] = seg_cout[k-1];
        end

        adder_seg_stage #(.SEGW(SEGW)) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (adv),
            .a    (a_q[k-1][LO +: SEGW]),
            .b    (b_q[k-1][LO +: SEGW]),
            .cin  (seg_cin[k]),
            .sum  (seg_sum[k]),
            .cout (seg_cout[k])
        );

        // Stage k view of the sum: slice k-1 fresh from the adder, others from the skew buffer.
        for (genvar j = 0; j < NSEG; j++) begin : gen_slice
            localparam int unsigned JLO = seg_lo(j, SEGW);
            localparam int unsigned JHI = seg_hi(j, SEGW);
            if (j == k - 1) begin : gen_new
                assign done[k][JHI:JLO] = seg_sum[k];
            end else begin : gen_old
                assign done[k][JHI:JLO] = s_q[k][JHI:JLO];
            end
        end
    end
endmodule
